settings_spi_rx: RTL and testbench
==================================

Name: settings_spi_rx

Overview:
- SPI slave front end that receives 16-bit settings words from the host MCU.
- Presents each committed word to the settings register bank as a held 16-bit bus plus a one-cycle strobe.
- Word format matches the bank: [15:12] register-select address, [11:0] payload.
- Also shifts the previously committed word back out on sdo for host readback, and flags malformed frames.

Parameters:
- MAX_ADDR, 2, highest register-select address accepted; words with [15:12] > MAX_ADDR are dropped.
- IDLE_WORD, 16'hF000, reset value of dataOut; address field selects no register.

Ports:
- clk  input  1  system clock; must run at least 8x the sck frequency.
- rst  input  1  synchronous, active-high reset.
- sck  input  1  SPI clock from host, asynchronous to clk, mode 0 (sample on rising edge, shift on falling edge).
- cs_n  input  1  SPI chip select, active low, asynchronous.
- sdi  input  1  SPI data from host, MSB first.
- sdo  output  1  readback data to host, MSB first.
- dataOut  output  16  last committed settings word, held between commits.
- wordValid  output  1  one-cycle pulse in the cycle dataOut updates.
- frameErr  output  1  sticky; set on a bad frame, cleared on the next good commit.
- badAddr  output  1  sticky; set on a dropped out-of-range address, cleared on the next good commit.

Behaviour:
- Reset is synchronous: rst high at a clk edge forces:
  - dataOut=IDLE_WORD
  - wordValid=0, frameErr=0, badAddr=0
  - rx shift register=0, bitCnt=0, tx shift register=IDLE_WORD
  - sync flops to idle (sck=0, cs_n=1, sdi=0); sdo=0
- Reset mid-frame: discard the partial word. A frame in progress at reset release is ignored until cs_n has been seen high, then falls again.
- Synchronisers: sck, cs_n and sdi each pass through a 2-FF synchroniser. Edges are detected from the 2nd and a 3rd delayed stage.
- States: IDLE (cs_n high) and ACTIVE (cs_n low).
  - IDLE->ACTIVE on synced cs_n falling edge:
    - bitCnt<=0
    - txShift<=dataOut
  - ACTIVE->IDLE on synced cs_n rising edge; commit decision is made in this same cycle.
- ACTIVE, synced sck rising edge:
  - rxShift<={rxShift[14:0], sdi_sync}
  - bitCnt increments and saturates at 17 (5-bit counter).
- ACTIVE, synced sck falling edge: txShift<={txShift[14:0],1'b0}.
- sdo = txShift[15] while in ACTIVE, 0 in IDLE.
- Commit at ACTIVE->IDLE:
  - bitCnt==16 and rxShift[15:12]<=MAX_ADDR: dataOut<=rxShift, wordValid=1 for exactly that cycle, frameErr<=0, badAddr<=0.
  - bitCnt==16 and address > MAX_ADDR: no commit, badAddr<=1, dataOut unchanged.
  - bitCnt!=16 (short, long, or zero-bit frame): no commit, frameErr<=1, dataOut unchanged.
- Latency: pin cs_n rise to wordValid/dataOut update is 3 clk cycles (2 sync + 1 register).
- Simultaneous events:
  - An sck edge in the same synced cycle as the cs_n rise is ignored; the commit uses the pre-edge bitCnt/rxShift.
  - cs_n fall coincident with an sck rise: the load takes priority and that sck edge is ignored.
- dataOut is held indefinitely between commits. Repeated commits of the same word pulse wordValid each time.
- Back-to-back frames need cs_n high for at least 3 clk cycles.

Test Plan:
- Reset: pulse rst with frame traffic active -> dataOut=16'hF000, wordValid=0, frameErr=0, badAddr=0, sdo=0.
- Good word: send 16'h0A53 -> 3 clk after cs_n rise, dataOut=16'h0A53 with a single-cycle wordValid; next send 16'h1FA7 -> dataOut=16'h1FA7.
- Readback: after committing 16'h2C40, send a second frame -> sdo bits across that frame read 16'h2C40 MSB first.
- Bad length: frames of 15 and 17 bits -> no wordValid, dataOut unchanged, frameErr=1; then a good 16'h0123 -> frameErr=0, dataOut=16'h0123.
- Bad address: send 16'h3FFF with MAX_ADDR=2 -> no wordValid, badAddr=1, dataOut unchanged.
- Mid-frame reset: assert rst after 8 bits, release, finish the frame -> no commit; the next full frame commits normally.

Source files
------------

// File: rtl/settings_spi_rx.sv
// rtl/settings_spi_rx.sv - SPI mode-0 slave receiving 16-bit settings words with readback on sdo.
module settings_spi_rx #(
   parameter logic [3:0]  MAX_ADDR  = 4'd2,
   parameter logic [15:0] IDLE_WORD = 16'hF000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sck,
   input  logic        cs_n,
   input  logic        sdi,
   output logic        sdo,
   output logic [15:0] dataOut,
   output logic        wordValid,
   output logic        frameErr,
   output logic        badAddr
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

   logic [0:0]  state;
   logic [2:0]  sck_q;
   logic [2:0]  cs_q;
   logic [1:0]  sdi_q;
   logic [1:0]  warm;
   logic        armed;
   logic [15:0] rx_shift;
   logic [15:0] tx_shift;
   logic [4:0]  bit_cnt;

   logic sck_rise, sck_fall, cs_rise, cs_fall, sdi_sync;

   assign sdi_sync = sdi_q[1];
   assign sck_rise = sck_q[1] & ~sck_q[2];
   assign sck_fall = ~sck_q[1] & sck_q[2];
   assign cs_rise  = cs_q[1] & ~cs_q[2];
   assign cs_fall  = ~cs_q[1] & cs_q[2];

   assign sdo = (state == ST_ACTIVE) ? tx_shift[15] : 1'b0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         sck_q     <= 3'b000;
         cs_q      <= 3'b111;
         sdi_q     <= 2'b00;
         warm      <= 2'b00;
         armed     <= 1'b0;
         rx_shift  <= 16'h0000;
         tx_shift  <= IDLE_WORD;
         bit_cnt   <= 5'd0;
         dataOut   <= IDLE_WORD;
         wordValid <= 1'b0;
         frameErr  <= 1'b0;
         badAddr   <= 1'b0;
      end else begin
         sck_q     <= {sck_q[1:0], sck};
         cs_q      <= {cs_q[1:0], cs_n};
         sdi_q     <= {sdi_q[0], sdi};
         warm      <= {warm[0], 1'b1};
         wordValid <= 1'b0;
         // cs_q[1] only reflects the pin once warm[1] is set; a frame already
         // open when reset released must not be accepted until cs_n is seen high.
         if (warm[1] && cs_q[1])
            armed <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (cs_fall && armed) begin
                  state    <= ST_ACTIVE;
                  bit_cnt  <= 5'd0;
                  tx_shift <= dataOut;
               end
            end
            default: begin
               if (cs_rise) begin
                  state <= ST_IDLE;
                  if (bit_cnt != 5'd16) begin
                     frameErr <= 1'b1;
                  end else if (rx_shift[15:12] > MAX_ADDR) begin
                     badAddr <= 1'b1;
                  end else begin
                     dataOut   <= rx_shift;
                     wordValid <= 1'b1;
                     frameErr  <= 1'b0;
                     badAddr   <= 1'b0;
                  end
               end else if (sck_rise) begin
                  rx_shift <= {rx_shift[14:0], sdi_sync};
                  if (bit_cnt != 5'd17)
                     bit_cnt <= bit_cnt + 5'd1;
               end else if (sck_fall) begin
                  tx_shift <= {tx_shift[14:0], 1'b0};
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_settings_spi_rx.sv
// tb/tb_settings_spi_rx.sv - directed self-checking bench for settings_spi_rx.
module tb_settings_spi_rx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sck = 1'b0;
   logic        cs_n = 1'b1;
   logic        sdi = 1'b0;
   logic        sdo;
   logic [15:0] dataOut;
   logic        wordValid;
   logic        frameErr;
   logic        badAddr;

   int checks = 0;
   int errors = 0;
   int wv_count = 0;
   int wv_before;
   logic [31:0] rd;

   settings_spi_rx #(.MAX_ADDR(4'd2), .IDLE_WORD(16'hF000)) dut (
      .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n), .sdi(sdi), .sdo(sdo),
      .dataOut(dataOut), .wordValid(wordValid), .frameErr(frameErr), .badAddr(badAddr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (wordValid === 1'b1) wv_count = wv_count + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_start();
      cs_n = 1'b0;
      wait_neg(8);
   endtask

   task automatic spi_bit(input logic b, output logic so);
      sdi = b;
      wait_neg(8);
      sck = 1'b1;
      so = sdo;
      wait_neg(8);
      sck = 1'b0;
   endtask

   task automatic spi_end();
      wait_neg(8);
      cs_n = 1'b1;
   endtask

   task automatic send(input logic [31:0] w, input int n, output logic [31:0] rb);
      logic so;
      rb = 32'h0;
      spi_start();
      for (int i = 0; i < n; i++) begin
         spi_bit(w[n-1-i], so);
         rb = {rb[30:0], so};
      end
      spi_end();
   endtask

   task automatic expect_commit(input string tag, input logic [15:0] exp);
      @(posedge clk); @(posedge clk); #1;
      chk({tag, "_wv_early"}, {31'h0, wordValid}, 32'h0);
      @(posedge clk); #1;
      chk({tag, "_wv"}, {31'h0, wordValid}, 32'h1);
      chk({tag, "_data"}, {16'h0, dataOut}, {16'h0, exp});
      @(posedge clk); #1;
      chk({tag, "_wv_pulse"}, {31'h0, wordValid}, 32'h0);
      wait_neg(4);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_data"}, {16'h0, dataOut}, 32'h0000F000);
      chk({tag, "_wv"}, {31'h0, wordValid}, 32'h0);
      chk({tag, "_ferr"}, {31'h0, frameErr}, 32'h0);
      chk({tag, "_badaddr"}, {31'h0, badAddr}, 32'h0);
      chk({tag, "_sdo"}, {31'h0, sdo}, 32'h0);
   endtask

   initial begin
      logic so;
      wait_neg(4);
      check_reset_state("rst_init");
      rst = 1'b0;
      wait_neg(6);

      send(32'h0A53, 16, rd);
      expect_commit("w0A53", 16'h0A53);
      chk("w0A53_ferr", {31'h0, frameErr}, 32'h0);

      send(32'h1FA7, 16, rd);
      expect_commit("w1FA7", 16'h1FA7);

      send(32'h2C40, 16, rd);
      expect_commit("w2C40", 16'h2C40);
      chk("w2C40_badaddr", {31'h0, badAddr}, 32'h0);
      send(32'h0A53, 16, rd);
      expect_commit("rb_frame", 16'h0A53);
      chk("readback_2C40", rd, 32'h00002C40);

      wv_before = wv_count;
      send(32'h1234, 15, rd);
      wait_neg(8);
      chk("short_nowv", wv_count, wv_before);
      chk("short_ferr", {31'h0, frameErr}, 32'h1);
      chk("short_data", {16'h0, dataOut}, 32'h00000A53);

      send(32'h00123, 17, rd);
      wait_neg(8);
      chk("long_nowv", wv_count, wv_before);
      chk("long_ferr", {31'h0, frameErr}, 32'h1);
      chk("long_data", {16'h0, dataOut}, 32'h00000A53);

      send(32'h0123, 16, rd);
      expect_commit("w0123", 16'h0123);
      chk("w0123_ferr", {31'h0, frameErr}, 32'h0);
      chk("readback_0A53", rd, 32'h00000A53);

      wv_before = wv_count;
      send(32'h3FFF, 16, rd);
      wait_neg(8);
      chk("badaddr_nowv", wv_count, wv_before);
      chk("badaddr_flag", {31'h0, badAddr}, 32'h1);
      chk("badaddr_ferr", {31'h0, frameErr}, 32'h0);
      chk("badaddr_data", {16'h0, dataOut}, 32'h00000123);

      wv_before = wv_count;
      spi_start();
      for (int i = 0; i < 8; i++) spi_bit(i[0], so);
      rst = 1'b1;
      wait_neg(2);
      check_reset_state("rst_mid");
      rst = 1'b0;
      for (int i = 0; i < 8; i++) spi_bit(~i[0], so);
      spi_end();
      wait_neg(10);
      chk("midrst_nowv", wv_count, wv_before);
      chk("midrst_data", {16'h0, dataOut}, 32'h0000F000);
      chk("midrst_ferr", {31'h0, frameErr}, 32'h0);

      send(32'h2ABC, 16, rd);
      expect_commit("w2ABC", 16'h2ABC);
      chk("w2ABC_badaddr", {31'h0, badAddr}, 32'h0);
      chk("readback_idle", rd, 32'h0000F000);

      send(32'h2ABC, 16, rd);
      expect_commit("w2ABC_again", 16'h2ABC);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
